dmem_access_ctrl: RTL and testbench

Multi-cycle sequencer between the core's memory-control decode (MemRead/MemWrite/Funct3) and a variable-latency data memory with a req/ack handshake. It stalls the core while an access is outstanding and generates byte enables. It also extracts and sign/zero-extends load data, and flags misaligned accesses, bus errors and timeouts. It sits between the decode/ALU stage and the data memory, in place of a direct single-cycle memory hookup.

---
 rtl/dmem_access_ctrl.sv | 141 ++++++++++++++
 tb/tb_dmem_access_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/dmem_access_ctrl.sv
// Load/store sequencer between decode and a variable-latency data memory.
// Stalls the core while a req/ack access is outstanding; aborts on misalignment, bus error or timeout.
module dmem_access_ctrl #(
   parameter int ADDR_W         = 9,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              MemRead,
   input  logic              MemWrite,
   input  logic [2:0]        Funct3,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       wdata,
   output logic [31:0]       rdata,
   output logic              stall,
   output logic              done,
   output logic              fault,
   output logic [1:0]        fault_cause,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [3:0]        mem_be,
   output logic [31:0]       mem_wdata,
   input  logic              mem_ack,
   input  logic              mem_err,
   input  logic [31:0]       mem_rdata
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, REQ, DONE, ERR} state_t;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [1:0]       off;
   logic [1:0]       size;
   logic             uns;
   logic [1:0]       cause_nxt;
   logic             is_b, is_h, is_w, misaligned;
   logic [3:0]       be_nxt;
   logic [31:0]      wdata_nxt, lane, load_val;

   // Funct3 011/110/111 decode as word accesses
   assign is_b = (Funct3[1:0] == 2'b00);
   assign is_h = (Funct3[1:0] == 2'b01);
   assign is_w = Funct3[1];
   assign misaligned = (is_h & addr[0]) | (is_w & (addr[1:0] != 2'b00));

   always_comb begin
      be_nxt    = 4'b1111;
      wdata_nxt = wdata;
      if (is_b) begin
         be_nxt    = 4'b0001 << addr[1:0];
         wdata_nxt = {4{wdata[7:0]}};
      end else if (is_h) begin
         be_nxt    = 4'b0011 << {addr[1], 1'b0};
         wdata_nxt = {2{wdata[15:0]}};
      end
   end

   assign lane = mem_rdata >> {off, 3'b000};

   always_comb begin
      case (size)
         2'b00:   load_val = uns ? {24'b0, lane[7:0]}  : {{24{lane[7]}}, lane[7:0]};
         2'b01:   load_val = uns ? {16'b0, lane[15:0]} : {{16{lane[15]}}, lane[15:0]};
         default: load_val = mem_rdata;
      endcase
   end

   always_comb begin
      state_nxt = state;
      cause_nxt = fault_cause;
      case (state)
         IDLE: begin
            if (MemRead & MemWrite) begin
               state_nxt = ERR;
               cause_nxt = 2'b01;
            end else if (MemRead | MemWrite) begin
               if (misaligned) begin
                  state_nxt = ERR;
                  cause_nxt = 2'b01;
               end else begin
                  state_nxt = REQ;
               end
            end
         end
         REQ: begin
            // an ack in the final wait cycle beats the timeout
            if (mem_ack) begin
               state_nxt = mem_err ? ERR : DONE;
               if (mem_err) cause_nxt = 2'b10;
            end else if (cnt == CNT_LAST) begin
               state_nxt = ERR;
               cause_nxt = 2'b11;
            end
         end
         DONE:    state_nxt = IDLE;
         ERR:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         fault_cause <= 2'b00;
         cnt         <= '0;
         off         <= 2'b00;
         size        <= 2'b00;
         uns         <= 1'b0;
         mem_we      <= 1'b0;
         mem_addr    <= '0;
         mem_be      <= 4'b0000;
         mem_wdata   <= 32'b0;
         rdata       <= 32'b0;
      end else begin
         state       <= state_nxt;
         fault_cause <= cause_nxt;
         if (state == IDLE && state_nxt == REQ) begin
            mem_addr  <= {addr[ADDR_W-1:2], 2'b00};
            mem_we    <= MemWrite;
            mem_be    <= be_nxt;
            mem_wdata <= wdata_nxt;
            off       <= addr[1:0];
            size      <= Funct3[1:0];
            uns       <= Funct3[2];
            cnt       <= '0;
         end
         if (state == REQ && !mem_ack) cnt <= cnt + CNT_W'(1);
         if (state == REQ && mem_ack && !mem_err && !mem_we) rdata <= load_val;
      end
   end

   assign stall   = ((state == IDLE) & (MemRead | MemWrite)) | (state == REQ);
   assign mem_req = (state == REQ);
   assign done    = (state == DONE);
   assign fault   = (state == ERR);

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl with a short timeout so every abort path is reachable.
module tb_dmem_access_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        MemRead = 1'b0, MemWrite = 1'b0;
   logic [2:0]  Funct3 = 3'b000;
   logic [8:0]  addr = '0;
   logic [31:0] wdata = '0;
   logic [31:0] rdata;
   logic        stall, done, fault;
   logic [1:0]  fault_cause;
   logic        mem_req, mem_we;
   logic [8:0]  mem_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic        mem_ack = 1'b0, mem_err = 1'b0;
   logic [31:0] mem_rdata = '0;

   int errors = 0;
   int checks = 0;

   int          o_stall, o_req, o_done, o_fault;
   logic [31:0] o_rdata, o_wdata;
   logic [1:0]  o_cause;
   logic [8:0]  o_addr;
   logic [3:0]  o_be;
   logic        o_we;

   dmem_access_ctrl #(.ADDR_W(9), .TIMEOUT_CYCLES(4)) dut (
      .clk(clk), .rst_n(rst_n), .MemRead(MemRead), .MemWrite(MemWrite), .Funct3(Funct3),
      .addr(addr), .wdata(wdata), .rdata(rdata), .stall(stall), .done(done), .fault(fault),
      .fault_cause(fault_cause), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_err(mem_err),
      .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   // Drives one access for a fixed window and records what the DUT did.
   // ack_at: REQ cycle (1-based) on which mem_ack is raised, 0 = never.
   task automatic do_access(input logic rd, input logic wr, input logic [2:0] f3,
                            input logic [8:0] a, input logic [31:0] wd, input int ack_at,
                            input logic err, input logic [31:0] rdat);
      MemRead = rd; MemWrite = wr; Funct3 = f3; addr = a; wdata = wd;
      o_stall = 0; o_req = 0; o_done = 0; o_fault = 0;
      o_rdata = 'x; o_cause = 'x; o_addr = 'x; o_be = 'x; o_we = 1'bx; o_wdata = 'x;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         if (stall) o_stall++;
         if (mem_req) begin
            o_req++;
            if (o_req == 1) begin
               o_addr = mem_addr; o_be = mem_be; o_we = mem_we; o_wdata = mem_wdata;
            end
         end
         if (done) begin
            o_done++; o_rdata = rdata; MemRead = 1'b0; MemWrite = 1'b0;
         end
         if (fault) begin
            o_fault++; o_cause = fault_cause; MemRead = 1'b0; MemWrite = 1'b0;
         end
         mem_ack   = mem_req && (o_req == ack_at);
         mem_err   = err;
         mem_rdata = rdat;
      end
      mem_ack = 1'b0; mem_err = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      #3;
      checks++; if (stall !== 1'b0 || done !== 1'b0 || fault !== 1'b0) begin errors++;
         $display("FAIL reset_flags: stall=%b done=%b fault=%b want 000", stall, done, fault); end
      checks++; if (mem_req !== 1'b0 || mem_we !== 1'b0 || mem_be !== 4'h0) begin errors++;
         $display("FAIL reset_mem: req=%b we=%b be=%h want 0 0 0", mem_req, mem_we, mem_be); end
      checks++; if (mem_addr !== 9'h0 || mem_wdata !== 32'h0 || rdata !== 32'h0 || fault_cause !== 2'b00) begin
         errors++; $display("FAIL reset_data: addr=%h wdata=%h rdata=%h cause=%b want zeros",
                            mem_addr, mem_wdata, rdata, fault_cause); end
      @(posedge clk); #1 rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_load_word();
      do_access(1, 0, 3'b010, 9'h010, 32'h0, 1, 0, 32'hDEADBEEF);
      checks++; if (o_addr !== 9'h010 || o_be !== 4'b1111 || o_we !== 1'b0) begin errors++;
         $display("FAIL lw_mem: addr=%h be=%b we=%b want 010 1111 0", o_addr, o_be, o_we); end
      checks++; if (o_stall !== 2 || o_req !== 1 || o_done !== 1 || o_fault !== 0) begin errors++;
         $display("FAIL lw_timing: stall=%0d req=%0d done=%0d fault=%0d want 2 1 1 0",
                  o_stall, o_req, o_done, o_fault); end
      checks++; if (o_rdata !== 32'hDEADBEEF) begin errors++;
         $display("FAIL lw_rdata: got %h want deadbeef", o_rdata); end
   endtask

   task automatic test_load_byte();
      do_access(1, 0, 3'b000, 9'h013, 32'h0, 1, 0, 32'h80123456);
      checks++; if (o_be !== 4'b1000 || o_addr !== 9'h010) begin errors++;
         $display("FAIL lb_mem: be=%b addr=%h want 1000 010", o_be, o_addr); end
      checks++; if (o_rdata !== 32'hFFFFFF80) begin errors++;
         $display("FAIL lb_rdata: got %h want ffffff80", o_rdata); end
      do_access(1, 0, 3'b100, 9'h013, 32'h0, 1, 0, 32'h80123456);
      checks++; if (o_rdata !== 32'h00000080) begin errors++;
         $display("FAIL lbu_rdata: got %h want 00000080", o_rdata); end
   endtask

   task automatic test_load_half();
      do_access(1, 0, 3'b001, 9'h012, 32'h0, 1, 0, 32'h80011234);
      checks++; if (o_be !== 4'b1100 || o_rdata !== 32'hFFFF8001) begin errors++;
         $display("FAIL lh_hi: be=%b rdata=%h want 1100 ffff8001", o_be, o_rdata); end
      do_access(1, 0, 3'b101, 9'h010, 32'h0, 2, 0, 32'h1234F00D);
      checks++; if (o_be !== 4'b0011 || o_rdata !== 32'h0000F00D) begin errors++;
         $display("FAIL lhu_lo: be=%b rdata=%h want 0011 0000f00d", o_be, o_rdata); end
   endtask

   task automatic test_store();
      do_access(0, 1, 3'b001, 9'h006, 32'h0000ABCD, 4, 0, 32'h0);
      checks++; if (o_we !== 1'b1 || o_be !== 4'b1100 || o_wdata !== 32'hABCDABCD || o_addr !== 9'h004) begin
         errors++; $display("FAIL sh_mem: we=%b be=%b wdata=%h addr=%h want 1 1100 abcdabcd 004",
                            o_we, o_be, o_wdata, o_addr); end
      checks++; if (o_req !== 4 || o_done !== 1 || o_stall !== 5 || o_fault !== 0) begin errors++;
         $display("FAIL sh_timing: req=%0d done=%0d stall=%0d fault=%0d want 4 1 5 0",
                  o_req, o_done, o_stall, o_fault); end
      checks++; if (rdata !== 32'h0000F00D) begin errors++;
         $display("FAIL sh_rdata_kept: got %h want 0000f00d", rdata); end
      do_access(0, 1, 3'b000, 9'h001, 32'h1234565A, 1, 0, 32'h0);
      checks++; if (o_be !== 4'b0010 || o_wdata !== 32'h5A5A5A5A) begin errors++;
         $display("FAIL sb_mem: be=%b wdata=%h want 0010 5a5a5a5a", o_be, o_wdata); end
   endtask

   task automatic test_misaligned();
      do_access(1, 0, 3'b010, 9'h002, 32'h0, 1, 0, 32'h0);
      checks++; if (o_req !== 0 || o_stall !== 1 || o_fault !== 1 || o_cause !== 2'b01 || o_done !== 0) begin
         errors++; $display("FAIL lw_misaligned: req=%0d stall=%0d fault=%0d cause=%b done=%0d want 0 1 1 01 0",
                            o_req, o_stall, o_fault, o_cause, o_done); end
      do_access(1, 1, 3'b010, 9'h010, 32'h0, 1, 0, 32'h0);
      checks++; if (o_req !== 0 || o_stall !== 1 || o_fault !== 1 || o_cause !== 2'b01) begin errors++;
         $display("FAIL rd_wr_both: req=%0d stall=%0d fault=%0d cause=%b want 0 1 1 01",
                  o_req, o_stall, o_fault, o_cause); end
      do_access(1, 0, 3'b101, 9'h011, 32'h0, 1, 0, 32'h0);
      checks++; if (o_req !== 0 || o_fault !== 1 || o_cause !== 2'b01) begin errors++;
         $display("FAIL lhu_misaligned: req=%0d fault=%0d cause=%b want 0 1 01", o_req, o_fault, o_cause); end
   endtask

   task automatic test_timeout();
      do_access(1, 0, 3'b010, 9'h020, 32'h0, 0, 0, 32'h0);
      checks++; if (o_req !== 4 || o_fault !== 1 || o_cause !== 2'b11 || o_done !== 0) begin errors++;
         $display("FAIL timeout: req=%0d fault=%0d cause=%b done=%0d want 4 1 11 0",
                  o_req, o_fault, o_cause, o_done); end
      checks++; if (rdata !== 32'h0000F00D) begin errors++;
         $display("FAIL timeout_rdata_kept: got %h want 0000f00d", rdata); end
      do_access(1, 0, 3'b010, 9'h020, 32'h0, 2, 1, 32'h11111111);
      checks++; if (o_req !== 2 || o_fault !== 1 || o_cause !== 2'b10 || o_done !== 0 || rdata !== 32'h0000F00D) begin
         errors++; $display("FAIL bus_err: req=%0d fault=%0d cause=%b done=%0d rdata=%h want 2 1 10 0 0000f00d",
                            o_req, o_fault, o_cause, o_done, rdata); end
      do_access(1, 0, 3'b010, 9'h020, 32'h0, 4, 0, 32'hCAFE0001);
      checks++; if (o_req !== 4 || o_done !== 1 || o_fault !== 0 || o_rdata !== 32'hCAFE0001) begin errors++;
         $display("FAIL ack_last: req=%0d done=%0d fault=%0d rdata=%h want 4 1 0 cafe0001",
                  o_req, o_done, o_fault, o_rdata); end
      checks++; if (fault_cause !== 2'b10) begin errors++;
         $display("FAIL cause_held: got %b want 10", fault_cause); end
   endtask

   task automatic test_reset_mid();
      int n_done, n_req;
      MemRead = 1'b1; MemWrite = 1'b0; Funct3 = 3'b010; addr = 9'h040;
      @(posedge clk); #1;
      @(posedge clk); #2;
      rst_n = 1'b0; MemRead = 1'b0;
      #1;
      checks++; if (mem_req !== 1'b0 || stall !== 1'b0) begin errors++;
         $display("FAIL rst_mid_drop: req=%b stall=%b want 0 0", mem_req, stall); end
      @(posedge clk); #1 rst_n = 1'b1;
      n_done = 0; n_req = 0;
      mem_ack = 1'b1; mem_rdata = 32'h55555555;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         if (done) n_done++;
         if (mem_req) n_req++;
         if (c == 1) mem_ack = 1'b0;
      end
      checks++; if (n_done !== 0 || n_req !== 0) begin errors++;
         $display("FAIL late_ack: done=%0d req=%0d want 0 0", n_done, n_req); end
      checks++; if (rdata !== 32'h0 || fault_cause !== 2'b00 || stall !== 1'b0 || mem_be !== 4'h0) begin errors++;
         $display("FAIL post_reset: rdata=%h cause=%b stall=%b be=%h want 0 00 0 0",
                  rdata, fault_cause, stall, mem_be); end
   endtask

   initial begin
      test_reset();
      test_load_word();
      test_load_byte();
      test_load_half();
      test_store();
      test_misaligned();
      test_timeout();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
